axis_frame_driver: RTL

- Initiator and stream peer for the AXI-stream frame buffer in the CNN datapath.
- Sequence per frame:
  - Requests a buffer transfer via the ex_start/ex_startAck handshake.
  - Streams NUMOFDATA words from a local TX memory into the buffer's slave side.
  - Captures the NUMOFDATA words the buffer returns on its master side into a local RX memory.
- Host side loads TX words, issues go, then reads RX words after done.

---
 rtl/axis_frame_driver.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/axis_frame_driver.sv
// Frame driver for the AXI-stream frame buffer: request, stream TX memory out, capture the return into RX memory.
// Optional stall watchdog is compiled in when AXIS_DRIVER_TIMEOUT_EN is defined.
module axis_frame_driver #(
    parameter int DATAWIDTH = 32,
    parameter int NUMOFDATA = 8,
    parameter int TIMEOUT   = 64,
    localparam int ADRWIDTH = $clog2(NUMOFDATA)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 host_wr_en,
    input  logic [ADRWIDTH-1:0]  host_wr_adr,
    input  logic [DATAWIDTH-1:0] host_wr_data,
    input  logic [ADRWIDTH-1:0]  host_rd_adr,
    output logic [DATAWIDTH-1:0] host_rd_data,
    input  logic                 go,
    output logic                 busy,
    output logic                 done,
    output logic                 err_last,
    output logic                 err_timeout,
    output logic                 ex_start,
    input  logic                 ex_startAck,
    output logic [DATAWIDTH-1:0] m_data,
    output logic                 m_valid,
    output logic                 m_last,
    input  logic                 m_ready,
    input  logic [DATAWIDTH-1:0] s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_SEND = 3'd2,
        S_RECV = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [ADRWIDTH-1:0] LAST_ADR = ADRWIDTH'(NUMOFDATA - 1);
    localparam logic [ADRWIDTH-1:0] CNT_ONE  = {{(ADRWIDTH-1){1'b0}}, 1'b1};

    state_t                state_r;
    logic [ADRWIDTH-1:0]   cnt_r;
    logic [ADRWIDTH-1:0]   cnt_inc_s;
    logic                  cnt_last_s;
    logic                  timeout_hit_s;
    logic [DATAWIDTH-1:0]  tx_mem [NUMOFDATA];
    logic [DATAWIDTH-1:0]  rx_mem [NUMOFDATA];

    logic                  busy_r;
    logic                  done_r;
    logic                  err_last_r;
    logic                  err_timeout_r;
    logic                  ex_start_r;
    logic [DATAWIDTH-1:0]  m_data_r;
    logic                  m_valid_r;
    logic                  m_last_r;
    logic                  s_ready_r;

    assign cnt_inc_s  = cnt_r + CNT_ONE;
    assign cnt_last_s = (cnt_r == LAST_ADR);

    assign host_rd_data = rx_mem[host_rd_adr];
    assign busy         = busy_r;
    assign done         = done_r;
    assign err_last     = err_last_r;
    assign err_timeout  = err_timeout_r;
    assign ex_start     = ex_start_r;
    assign m_data       = m_data_r;
    assign m_valid      = m_valid_r;
    assign m_last       = m_last_r;
    assign s_ready      = s_ready_r;

`ifdef AXIS_DRIVER_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_ONE = {{(WDW-1){1'b0}}, 1'b1};
    localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

    logic [WDW-1:0] wd_r;
    logic           wd_active_s;
    logic           wd_progress_s;

    // Watchdog qualifiers: which states are watched and what counts as progress there.
    always_comb begin
        wd_active_s   = 1'b0;
        wd_progress_s = 1'b0;
        case (state_r)
            S_REQ:  begin wd_active_s = 1'b1; wd_progress_s = ex_startAck; end
            S_SEND: begin wd_active_s = 1'b1; wd_progress_s = m_ready;     end
            S_RECV: begin wd_active_s = 1'b1; wd_progress_s = s_valid;     end
            default: begin wd_active_s = 1'b0; wd_progress_s = 1'b0; end
        endcase
    end

    // Stall counter; every state change is either progress or an abort, so both clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_r <= '0;
        end else if (!wd_active_s || wd_progress_s || timeout_hit_s) begin
            wd_r <= '0;
        end else begin
            wd_r <= wd_r + WD_ONE;
        end
    end

    assign timeout_hit_s = wd_active_s && (wd_r == WD_MAX);
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Host-side TX memory; writable only while idle so a running frame never sees a change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUMOFDATA; i++) tx_mem[i] <= '0;
        end else if ((state_r == S_IDLE) && host_wr_en) begin
            tx_mem[host_wr_adr] <= host_wr_data;
        end
    end

    // RX capture memory, filled in order by the shared word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUMOFDATA; i++) rx_mem[i] <= '0;
        end else if ((state_r == S_RECV) && s_valid) begin
            rx_mem[cnt_r] <= s_data;
        end
    end

    // Frame sequencer with all handshake outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            cnt_r         <= '0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_last_r    <= 1'b0;
            err_timeout_r <= 1'b0;
            ex_start_r    <= 1'b0;
            m_data_r      <= '0;
            m_valid_r     <= 1'b0;
            m_last_r      <= 1'b0;
            s_ready_r     <= 1'b0;
        end else if (timeout_hit_s) begin
            state_r       <= S_DONE;
            done_r        <= 1'b1;
            err_timeout_r <= 1'b1;
            ex_start_r    <= 1'b0;
            m_data_r      <= '0;
            m_valid_r     <= 1'b0;
            m_last_r      <= 1'b0;
            s_ready_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    cnt_r <= '0;
                    if (go) begin
                        state_r       <= S_REQ;
                        busy_r        <= 1'b1;
                        ex_start_r    <= 1'b1;
                        err_last_r    <= 1'b0;
                        err_timeout_r <= 1'b0;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (ex_startAck) begin
                        state_r    <= S_SEND;
                        ex_start_r <= 1'b0;
                        cnt_r      <= '0;
                        m_valid_r  <= 1'b1;
                        m_data_r   <= tx_mem[0];
                        m_last_r   <= 1'b0;
                    end else begin
                        state_r <= S_REQ;
                    end
                end
                S_SEND: begin
                    if (m_ready && cnt_last_s) begin
                        state_r   <= S_RECV;
                        cnt_r     <= '0;
                        m_valid_r <= 1'b0;
                        m_last_r  <= 1'b0;
                        m_data_r  <= '0;
                        s_ready_r <= 1'b1;
                    end else if (m_ready) begin
                        cnt_r    <= cnt_inc_s;
                        m_data_r <= tx_mem[cnt_inc_s];
                        m_last_r <= (cnt_inc_s == LAST_ADR);
                    end else begin
                        state_r <= S_SEND;
                    end
                end
                S_RECV: begin
                    if (s_valid) begin
                        // A misplaced s_last is only flagged; the count alone ends the frame.
                        if (s_last != cnt_last_s) begin
                            err_last_r <= 1'b1;
                        end else begin
                            err_last_r <= err_last_r;
                        end
                        if (cnt_last_s) begin
                            state_r   <= S_DONE;
                            s_ready_r <= 1'b0;
                            done_r    <= 1'b1;
                            cnt_r     <= '0;
                        end else begin
                            cnt_r <= cnt_inc_s;
                        end
                    end else begin
                        state_r <= S_RECV;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= '0;
                end
                default: begin
                    state_r    <= S_IDLE;
                    busy_r     <= 1'b0;
                    cnt_r      <= '0;
                    ex_start_r <= 1'b0;
                    m_valid_r  <= 1'b0;
                    m_last_r   <= 1'b0;
                    s_ready_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule
